data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit words stored (power of two, 4..4096).
REQ-002 SHALL have parameter LATENCY, default 2, clock cycles from request acceptance to response (1..15).
REQ-003 SHALL have port clk input 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset input 1: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid input 1: pipeline memory-stage request present.
REQ-006 SHALL have port req_we input 1: 1 = store (mem_w), 0 = load (mem_r).
REQ-007 SHALL have port req_addr input 32: byte address (ALU result).
REQ-008 SHALL have port req_wdata input 32: store value.
REQ-009 SHALL have port req_ready output 1: responder can accept a request this cycle.
REQ-010 SHALL have port resp_valid output 1: single-cycle response pulse.
REQ-011 SHALL have port resp_rdata output 32: load data; 0 for stores.
REQ-012 SHALL have port resp_err output 1: misaligned-access flag, valid with resp_valid.
REQ-013 SHALL have port stall output 1: hold the pipeline; equals req_valid AND NOT req_ready.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-015 SHALL drive req_ready high in IDLE and RESP only.
REQ-016 SHALL accept a request on a rising edge where req_valid and req_ready are both high, and SHALL capture req_we, req_addr and req_wdata at that edge.
REQ-017 SHALL transition on accept to BUSY, or directly to RESP when LATENCY = 1.
REQ-018 SHALL load a down-counter with LATENCY-1 on entering BUSY, decrement it each BUSY cycle, and enter RESP on the edge where it reaches 0.
REQ-019 SHALL assert resp_valid for exactly one cycle, in RESP, exactly LATENCY cycles after the accept edge.
REQ-020 SHALL, in RESP, return to IDLE without a new accept, or restart at REQ-017 with a new accept (back-to-back throughput: one request per LATENCY cycles).
REQ-021 SHALL form the word index from req_addr[log2(DEPTH_WORDS)+1:2], ignore upper address bits, and wrap addresses modulo DEPTH_WORDS words.
REQ-022 SHALL commit a store to the array on the edge entering RESP.
REQ-023 SHALL sample load data on the edge entering RESP, so it reflects every earlier committed store, including one to the same address in the immediately preceding request.
REQ-024 SHALL hold resp_rdata at 0 outside RESP, and for stores.
REQ-025 SHALL ignore req_valid while in BUSY; the request stays pending and stall is high.

Reset
REQ-026 SHALL, while reset is low, force state IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0 and req_ready 0.
REQ-027 SHALL raise req_ready in the first cycle after reset deasserts.
REQ-028 SHALL discard an in-flight request on reset mid-operation: a pending store is not committed and no response is issued.
REQ-029 SHALL leave array contents unaffected by reset.

Configuration
REQ-030 SHALL, with DMEM_MISALIGN_CHECK_EN defined, treat a request with req_addr[1:0] != 0 as misaligned: no array write, resp_rdata 0, resp_err 1 in RESP, latency unchanged.
REQ-031 SHALL, without DMEM_MISALIGN_CHECK_EN, tie resp_err to 0 and ignore req_addr[1:0].

Structure
REQ-032 SHALL take the state enum, the default DEPTH_WORDS and LATENCY values, and the counter width constant from shared package dmem_pkg.
REQ-033 SHALL place storage in one sub-module, dmem_array: synchronous write, registered read, no reset; the FSM and counter stay in data_mem_responder.

Verification
REQ-034 SHALL cover: LATENCY=2, store 0xDEADBEEF to 0x10, then load 0x10 -> second resp_valid exactly 2 cycles after its accept, resp_rdata = 0xDEADBEEF.
REQ-035 SHALL cover: DEPTH_WORDS=256, store 0x1234 to 0x400, then load 0x000 -> 0x1234 (wrap-around).
REQ-036 SHALL cover: req_valid held high for 3 requests, LATENCY=3 -> accepts at cycles 0, 3 and 6, stall high in each BUSY cycle, 3 responses.
REQ-037 SHALL cover: reset pulsed low in BUSY during a store of 0xAAAA to 0x20 -> no resp_valid, and a later load of 0x20 returns the prior contents.
REQ-038 SHALL cover: with DMEM_MISALIGN_CHECK_EN, store to 0x22 -> resp_err 1, resp_rdata 0, word 0x20 unchanged; without the macro, same stimulus writes word 0x20 and resp_err stays 0.
REQ-039 SHALL cover: LATENCY=1, alternating store/load to 0x8 each cycle -> resp_valid every cycle, each load returns the previous store's data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
package dmem_pkg;
  localparam int unsigned DEPTH_WORDS_DEF = 256;
  localparam int unsigned LATENCY_DEF     = 2;
  // Wide enough to hold LATENCY-1 for the largest LATENCY of 15.
  localparam int unsigned CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between the pipeline memory stage and the responder.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );
endinterface

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, no reset so contents survive reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic          we_i,
  input  logic [AW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[idx_i] <= wdata_i;
      else      rdata_q      <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory responder; FSM IDLE -> BUSY (counting) -> RESP (one-cycle pulse).
// DMEM_MISALIGN_CHECK_EN enables flagging of non-word-aligned accesses via resp_err.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned LATENCY     = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  data_mem_responder_if.slave  bus
);
  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cap_we_q;
  logic [AW-1:0]     cap_idx_q;
  logic [1:0]        cap_lo_q;
  logic [31:0]       cap_wdata_q;
  logic              resp_we_q, resp_err_q;

  logic              ready, accept, enter_resp;
  logic              op_we, op_mis;
  logic [AW-1:0]     op_idx;
  logic [1:0]        op_lo;
  logic [31:0]       op_wdata, arr_rdata;
  logic              unused_bits;

  assign ready  = reset && (state_q != BUSY);
  assign accept = bus.req_valid && ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = BUSY;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // With single-cycle latency the commit happens on the accept edge itself, so use the live bus.
  assign op_we    = (LATENCY == 1) ? bus.req_we               : cap_we_q;
  assign op_idx   = (LATENCY == 1) ? bus.req_addr[AW+1:2]     : cap_idx_q;
  assign op_lo    = (LATENCY == 1) ? bus.req_addr[1:0]        : cap_lo_q;
  assign op_wdata = (LATENCY == 1) ? bus.req_wdata            : cap_wdata_q;

`ifdef DMEM_MISALIGN_CHECK_EN
  assign op_mis      = (op_lo != 2'b00);
  assign unused_bits = ^bus.req_addr[31:AW+2];
`else
  assign op_mis      = 1'b0;
  assign unused_bits = ^{bus.req_addr[31:AW+2], op_lo};
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cap_we_q    <= 1'b0;
      cap_idx_q   <= '0;
      cap_lo_q    <= '0;
      cap_wdata_q <= '0;
      resp_we_q   <= 1'b0;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        cap_we_q    <= bus.req_we;
        cap_idx_q   <= bus.req_addr[AW+1:2];
        cap_lo_q    <= bus.req_addr[1:0];
        cap_wdata_q <= bus.req_wdata;
      end
      if (enter_resp) begin
        resp_we_q  <= op_we;
        resp_err_q <= op_mis;
      end
    end
  end

  dmem_array #(.DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .en_i    (enter_resp),
    .we_i    (op_we && !op_mis),
    .idx_i   (op_idx),
    .wdata_i (op_wdata),
    .rdata_o (arr_rdata)
  );

  assign bus.req_ready  = ready;
  assign bus.stall      = bus.req_valid && !ready;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = (state_q == RESP) && resp_err_q;
  assign bus.resp_rdata = ((state_q == RESP) && !resp_we_q && !resp_err_q) ? arr_rdata : '0;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: three responders (LATENCY 1, 2, 3) checked every cycle against a request/due-edge model.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  valid_t, we_t;
  logic [31:0] addr_t [3];
  logic [31:0] wd_t   [3];
  wire  [2:0]  rdy_o, rv_o, err_o, stall_o;
  wire  [31:0] rd_o   [3];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : gd
      data_mem_responder_if bus ();
      assign bus.req_valid = valid_t[g];
      assign bus.req_we    = we_t[g];
      assign bus.req_addr  = addr_t[g];
      assign bus.req_wdata = wd_t[g];
      assign rdy_o[g]      = bus.req_ready;
      assign rv_o[g]       = bus.resp_valid;
      assign rd_o[g]       = bus.resp_rdata;
      assign err_o[g]      = bus.resp_err;
      assign stall_o[g]    = bus.stall;
      data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(g + 1)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    end
  endgenerate

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: a request accepted at edge e completes (commit/sample) at edge e+LATENCY-1,
  // the response is visible in the cycle after that edge; ready is low while one is pending.
  int          cyc = 0;
  bit          m_pend [3], m_rv [3], m_err [3], m_rdok [3], m_we [3];
  int          m_due  [3];
  logic [31:0] m_addr [3], m_wd [3], m_rd [3];
  logic [31:0] mmem   [3][256];
  bit          known  [3][256];
  bit          mis;
  int          idx;

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (!reset) begin
        m_pend[d] = 0; m_rv[d] = 0; m_err[d] = 0; m_rd[d] = 0; m_rdok[d] = 1;
      end else begin
        m_rv[d] = 0; m_err[d] = 0; m_rd[d] = 0; m_rdok[d] = 1;
        if (valid_t[d] && !m_pend[d]) begin
          m_pend[d] = 1; m_due[d] = cyc + d;
          m_we[d] = we_t[d]; m_addr[d] = addr_t[d]; m_wd[d] = wd_t[d];
        end
        if (m_pend[d] && m_due[d] == cyc) begin
          m_pend[d] = 0; m_rv[d] = 1;
          idx = int'(m_addr[d][9:2]);
`ifdef DMEM_MISALIGN_CHECK_EN
          mis = (m_addr[d][1:0] != 2'b00);
`else
          mis = 0;
`endif
          if (mis) m_err[d] = 1;
          else if (m_we[d]) begin mmem[d][idx] = m_wd[d]; known[d][idx] = 1; end
          else begin m_rd[d] = mmem[d][idx]; m_rdok[d] = known[d][idx]; end
        end
      end
    end
  end

  int stall_cnt [3];
  int resp_cnt  [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic er, ev;
      er = reset && !m_pend[d];
      ev = reset && m_rv[d];
      chk($sformatf("d%0d req_ready c%0d", d, cyc), 32'(rdy_o[d]), 32'(er));
      chk($sformatf("d%0d resp_valid c%0d", d, cyc), 32'(rv_o[d]), 32'(ev));
      chk($sformatf("d%0d resp_err c%0d", d, cyc), 32'(err_o[d]), 32'(ev && m_err[d]));
      chk($sformatf("d%0d stall c%0d", d, cyc), 32'(stall_o[d]), 32'(valid_t[d] && !er));
      if (!ev || m_rdok[d])
        chk($sformatf("d%0d resp_rdata c%0d", d, cyc), rd_o[d], ev ? m_rd[d] : 32'h0);
      if (stall_o[d]) stall_cnt[d]++;
      if (rv_o[d])    resp_cnt[d]++;
    end
  end

  // Called and returns at posedge+1; acc_edge is the edge number that accepted the request.
  task automatic req(input int d, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     output int acc_edge);
    logic r;
    valid_t[d] = 1'b1; we_t[d] = we; addr_t[d] = addr; wd_t[d] = wd;
    acc_edge = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk); r = rdy_o[d];
      @(posedge clk); #1;
      if (r) begin acc_edge = cyc; return; end
    end
    checks++; errors++;
    $display("FAIL d%0d accept timeout actual=none required=accept", d);
  endtask

  // resp_edge is the edge at which the pipeline samples the response pulse.
  task automatic wait_resp(input int d, output int resp_edge, output logic [31:0] rd,
                           output logic er);
    resp_edge = -1; rd = 'x; er = 1'bx;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rv_o[d]) begin
        resp_edge = cyc + 1; rd = rd_o[d]; er = err_o[d];
        @(posedge clk); #1;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL d%0d response timeout actual=none required=resp_valid", d);
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, a2, e, sc, rc;
    logic [31:0] rd;
    logic er;
    valid_t = '0; we_t = '0;
    for (int d = 0; d < 3; d++) begin addr_t[d] = '0; wd_t[d] = '0; end

    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("d%0d reset ready", d), 32'(rdy_o[d]), 32'h0);
      chk($sformatf("d%0d reset resp_valid", d), 32'(rv_o[d]), 32'h0);
      chk($sformatf("d%0d reset resp_rdata", d), rd_o[d], 32'h0);
    end
    #1 reset = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      chk($sformatf("d%0d ready after reset", d), 32'(rdy_o[d]), 32'h1);
    @(posedge clk); #1;

    // Store then load the same word, LATENCY 2.
    req(1, 1, 32'h10, 32'hDEADBEEF, a0); valid_t[1] = 0; wait_resp(1, e, rd, er);
    req(1, 0, 32'h10, 32'h0, a0);        valid_t[1] = 0; wait_resp(1, e, rd, er);
    chk("s1 load latency", 32'(e - a0), 32'd2);
    chk("s1 load data", rd, 32'hDEADBEEF);

    // Address wrap: byte 0x400 is word 256 which aliases word 0.
    req(1, 1, 32'h400, 32'h1234, a0); valid_t[1] = 0; wait_resp(1, e, rd, er);
    req(1, 0, 32'h000, 32'h0, a0);    valid_t[1] = 0; wait_resp(1, e, rd, er);
    chk("s2 wrap data", rd, 32'h1234);

    // Back-to-back with valid held, LATENCY 3.
    rc = resp_cnt[2];
    req(2, 1, 32'h100, 32'hA1, a0);
    sc = stall_cnt[2];
    req(2, 1, 32'h104, 32'hB2, a1);
    req(2, 0, 32'h100, 32'h0, a2);
    valid_t[2] = 0;
    chk("s3 stall cycles", 32'(stall_cnt[2] - sc), 32'd4);
    chk("s3 second accept", 32'(a1 - a0), 32'd3);
    chk("s3 third accept", 32'(a2 - a0), 32'd6);
    wait_resp(2, e, rd, er);
    chk("s3 load data", rd, 32'hA1);
    chk("s3 last latency", 32'(e - a2), 32'd3);
    chk("s3 response count", 32'(resp_cnt[2] - rc), 32'd3);

    // Reset in BUSY drops the in-flight store.
    req(1, 1, 32'h20, 32'h5555, a0); valid_t[1] = 0; wait_resp(1, e, rd, er);
    rc = resp_cnt[1];
    req(1, 1, 32'h20, 32'hAAAA, a0); valid_t[1] = 0;
    @(negedge clk); #1 reset = 1'b0;
    @(negedge clk); #1 reset = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("s4 no response", 32'(resp_cnt[1] - rc), 32'd0);
    req(1, 0, 32'h20, 32'h0, a0); valid_t[1] = 0; wait_resp(1, e, rd, er);
    chk("s4 prior contents", rd, 32'h5555);

    // Misaligned store to 0x22.
    req(1, 1, 32'h22, 32'hCAFEF00D, a0); valid_t[1] = 0; wait_resp(1, e, rd, er);
    chk("s5 store rdata", rd, 32'h0);
    req(1, 0, 32'h20, 32'h0, a0); valid_t[1] = 0; wait_resp(1, e, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    chk("s5 resp_err", 32'(er), 32'h0);
    chk("s5 word unchanged", rd, 32'h5555);
`else
    chk("s5 resp_err", 32'(er), 32'h0);
    chk("s5 word written", rd, 32'hCAFEF00D);
`endif

    // LATENCY 1: alternating store/load to 0x8 every cycle.
    valid_t[0] = 1; we_t[0] = 1; addr_t[0] = 32'h8; wd_t[0] = 32'h100;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); #1;
      chk($sformatf("s6 resp_valid %0d", i - 1), 32'(rv_o[0]), 32'h1);
      if ((i - 1) % 2 == 1)
        chk($sformatf("s6 load data %0d", i - 1), rd_o[0], 32'h100 + 32'(i - 2));
      else
        chk($sformatf("s6 store rdata %0d", i - 1), rd_o[0], 32'h0);
      if (i < 6) begin
        we_t[0] = (i % 2 == 0);
        wd_t[0] = 32'h100 + 32'(i);
      end
    end
    valid_t[0] = 0;

    repeat (5) @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
